// File: rtl/rbm_input_loader.sv
// ============================================================================
// Module   : rbm_input_loader
// Purpose  : Serial pixel loader for the RBM core. It packs INPUT_DIM pixels
//            into InputDataPort, holds data_valid until Main finishes, then
//            re-arms for the next image.
// Options  : Define CLAMP_NEG_EN to clamp negative pixels to 0 and large ones
//            to INF before they are stored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rbm_input_loader #(
    parameter int                    BITLENGTH = 12,
    parameter int                    INPUT_DIM = 4,
    parameter logic [BITLENGTH-1:0]  INF       = 12'b0111_1111_1111
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [BITLENGTH-1:0]           pixel_in,
    input  logic                           pixel_valid,
    input  logic                           pixel_last,
    output logic                           pixel_ready,
    input  logic                           finish,
    output logic                           data_valid,
    output logic [INPUT_DIM*BITLENGTH-1:0] InputDataPort,
    output logic                           frame_error,
    output logic [15:0]                    image_count
);

    localparam int CNT_W = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(INPUT_DIM - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        REARM = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BITLENGTH-1:0]  r_buf [INPUT_DIM];
    logic                  r_data_valid;
    logic                  r_frame_error;
    logic [15:0]           r_image_count;
    logic                  r_finish_d;

    logic                  w_accept;
    logic                  w_finish_rise;
    logic                  w_at_last;
    logic [BITLENGTH-1:0]  w_pixel;

    assign pixel_ready   = (r_state == LOAD) && !reset;
    assign w_accept      = pixel_valid && pixel_ready;
    assign w_finish_rise = finish && !r_finish_d;
    assign w_at_last     = (r_cnt == C_LAST_IDX);

`ifdef CLAMP_NEG_EN
    // The upper clamp only bites when INF is overridden below full range.
    always_comb begin
        w_pixel = pixel_in;
        if (pixel_in[BITLENGTH-1]) begin
            w_pixel = '0;
        end else if ($signed(pixel_in) > $signed(INF)) begin
            w_pixel = INF;
        end
    end
`else
    always_comb begin
        w_pixel = pixel_in;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= LOAD;
            r_cnt         <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_image_count <= 16'd0;
            r_finish_d    <= 1'b0;
            for (int i = 0; i < INPUT_DIM; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_finish_d    <= finish;
            r_frame_error <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_buf[r_cnt] <= w_pixel;
                        if (w_at_last && pixel_last) begin
                            r_cnt        <= '0;
                            r_data_valid <= 1'b1;
                            r_state      <= WAIT;
                        end else if (w_at_last || pixel_last) begin
                            // Early or missing last: drop the whole image.
                            r_cnt         <= '0;
                            r_frame_error <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (w_finish_rise) begin
                        r_data_valid <= 1'b0;
                        if (r_image_count != 16'hFFFF) begin
                            r_image_count <= r_image_count + 16'd1;
                        end
                        r_state <= REARM;
                    end
                end
                REARM: begin
                    r_state <= LOAD;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < INPUT_DIM; g++) begin : g_pack
            assign InputDataPort[(g+1)*BITLENGTH-1 : g*BITLENGTH] = r_buf[g];
        end
    endgenerate

    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign image_count = r_image_count;

endmodule

`default_nettype wire
